ld_align_merge: RTL and testbench

Load-data alignment stage for unaligned loads of 1–16 bytes. It accepts a load request (byte offset, size), collects one or two 128-bit memory beats, and byte-rotates each beat with the shared byte rotator. It then merges the rotated beats so that requested byte 0 lands in bit lane [7:0], and returns a zero- or sign-filled 128-bit result. It sits between the memory read-return path and the load writeback path.

---
 rtl/ld_align_pkg.sv | 24 ++
 rtl/ld_align_merge_shift.sv | 18 +
 rtl/ld_align_merge.sv | 149 ++++++++++++++
 tb/tb_ld_align_merge.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ld_align_pkg.sv
// Shared constants, FSM state encoding and the byte keep-mask helper for ld_align_merge.
package ld_align_pkg;

  localparam int DATA_W = 128;
  localparam int BYTES  = 16;
  localparam int OFF_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_B0 = 2'd1,
    ST_WAIT_B1 = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Bit i set when result byte i is a requested byte (i <= size).
  function automatic logic [BYTES-1:0] keep_mask(input logic [OFF_W-1:0] size);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) begin
      m[i] = (4'(i) <= size);
    end
    return m;
  endfunction

endpackage

// File: rtl/ld_align_merge_shift.sv
// Byte rotator: output byte i = input byte (i + offset) mod 16.
module data_byte_shift
  import ld_align_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [OFF_W-1:0]  i_offset,
  output logic [DATA_W-1:0] o_data
);

  logic [2*DATA_W-1:0] w_double;

  // Rotate by shifting a doubled copy right by offset bytes.
  always_comb begin
    w_double = {i_data, i_data} >> {i_offset, 3'b000};
    o_data   = w_double[DATA_W-1:0];
  end

endmodule

// File: rtl/ld_align_merge.sv
// Unaligned load alignment/merge stage (1-16 bytes, up to two beats).
// Optional sign fill enabled by defining LD_ALIGN_SEXT_EN.
module ld_align_merge
  import ld_align_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic [OFF_W-1:0]  req_size,
  input  logic              req_signed,
  input  logic              beat_valid,
  output logic              beat_ready,
  input  logic [DATA_W-1:0] beat_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data
);

  state_e            r_state, w_state_nxt;
  logic [OFF_W-1:0]  r_off, r_size;
  logic [DATA_W-1:0] r_rot0, r_rsp;
  logic [DATA_W-1:0] w_rot, w_merged, w_fill_data;
  logic [BYTES-1:0]  w_keep;
  logic [7:0]        w_fill_byte;
  logic [4:0]        w_span_sum;
  logic              w_span, w_rsp_load;

`ifdef LD_ALIGN_SEXT_EN
  logic r_sgn;
`else
  logic w_unused_signed;
  assign w_unused_signed = req_signed;
`endif

  assign req_ready  = (r_state == ST_IDLE);
  assign beat_ready = (r_state == ST_WAIT_B0) || (r_state == ST_WAIT_B1);
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_data   = r_rsp;

  data_byte_shift u_shift (
    .i_data   (beat_data),
    .i_offset (r_off),
    .o_data   (w_rot)
  );

  assign w_span_sum = {1'b0, r_off} + {1'b0, r_size};
  assign w_span     = (w_span_sum >= 5'd16);

  // Merge: low bytes come from the first beat until it runs out, the rest from the second.
  always_comb begin
    w_merged = w_rot;
    if (r_state == ST_WAIT_B1) begin
      for (int i = 0; i < BYTES; i++) begin
        if ((5'(i) + {1'b0, r_off}) < 5'd16) begin
          w_merged[8*i +: 8] = r_rot0[8*i +: 8];
        end else begin
          w_merged[8*i +: 8] = w_rot[8*i +: 8];
        end
      end
    end else begin
      w_merged = w_rot;
    end
  end

  // Fill bytes above the requested size with zero or the sign of the top requested byte.
  always_comb begin
    w_keep      = keep_mask(r_size);
    w_fill_byte = 8'h00;
`ifdef LD_ALIGN_SEXT_EN
    if (r_sgn && w_merged[{r_size, 3'b111}]) begin
      w_fill_byte = 8'hFF;
    end else begin
      w_fill_byte = 8'h00;
    end
`endif
    for (int i = 0; i < BYTES; i++) begin
      w_fill_data[8*i +: 8] = w_keep[i] ? w_merged[8*i +: 8] : w_fill_byte;
    end
  end

  // Next-state and response-load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_rsp_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_state_nxt = ST_WAIT_B0;
        else           w_state_nxt = ST_IDLE;
      end
      ST_WAIT_B0: begin
        if (beat_valid) begin
          if (w_span) begin
            w_state_nxt = ST_WAIT_B1;
          end else begin
            w_state_nxt = ST_RESP;
            w_rsp_load  = 1'b1;
          end
        end else begin
          w_state_nxt = ST_WAIT_B0;
        end
      end
      ST_WAIT_B1: begin
        if (beat_valid) begin
          w_state_nxt = ST_RESP;
          w_rsp_load  = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT_B1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_RESP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latched request fields, first rotated beat and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_off   <= 4'd0;
      r_size  <= 4'd0;
      r_rot0  <= 128'd0;
      r_rsp   <= 128'd0;
`ifdef LD_ALIGN_SEXT_EN
      r_sgn   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && req_valid) begin
        r_off  <= req_offset;
        r_size <= req_size;
`ifdef LD_ALIGN_SEXT_EN
        r_sgn  <= req_signed;
`endif
      end
      if ((r_state == ST_WAIT_B0) && beat_valid) begin
        r_rot0 <= w_rot;
      end
      if (w_rsp_load) begin
        r_rsp <= w_fill_data;
      end
    end
  end

endmodule

// File: tb/tb_ld_align_merge.sv
// Directed, table-driven bench for ld_align_merge plus hand-written back-pressure and reset sequences.
module tb_ld_align_merge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_signed, beat_valid, rsp_ready;
  logic [3:0]   req_offset, req_size;
  logic [127:0] beat_data;
  logic         req_ready, beat_ready, rsp_valid;
  logic [127:0] rsp_data;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] BEAT0 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] BEAT1 = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [127:0] SBEAT = 128'h0F0E0D0C0B0A09080706050492340100;
  localparam logic [127:0] PBEAT = 128'h0F0E0D0C0B0A09080706050412340100;

  typedef struct {
    string        name;
    logic [3:0]   off;
    logic [3:0]   size;
    logic         sgn;
    logic         two;
    logic [127:0] b0;
    logic [127:0] b1;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[10];

  ld_align_merge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_offset (req_offset),
    .req_size   (req_size),
    .req_signed (req_signed),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_data  (beat_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_ready(input string name);
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk({name, "_req_ready_timeout"}, 128'(req_ready), 128'd1);
  endtask

  task automatic run_load(input vec_t v);
    wait_req_ready(v.name);
    req_valid  = 1'b1;
    req_offset = v.off;
    req_size   = v.size;
    req_signed = v.sgn;
    step();
    req_valid = 1'b0;
    chk({v.name, "_b0_ready"}, 128'(beat_ready), 128'd1);
    chk({v.name, "_no_early_rsp"}, 128'(rsp_valid), 128'd0);
    beat_valid = 1'b1;
    beat_data  = v.b0;
    step();
    if (v.two) begin
      chk({v.name, "_b1_ready"}, 128'(beat_ready), 128'd1);
      chk({v.name, "_no_rsp_mid"}, 128'(rsp_valid), 128'd0);
      beat_data = v.b1;
      step();
    end
    beat_valid = 1'b0;
    chk({v.name, "_rsp_valid"}, 128'(rsp_valid), 128'd1);
    chk({v.name, "_data"}, rsp_data, v.exp);
    chk({v.name, "_beat_ready_off"}, 128'(beat_ready), 128'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({v.name, "_idle_again"}, 128'(req_ready), 128'd1);
    chk({v.name, "_rsp_dropped"}, 128'(rsp_valid), 128'd0);
  endtask

  initial begin
    vecs[0] = '{"o0s15", 4'd0, 4'd15, 1'b0, 1'b0, BEAT0, BEAT1, BEAT0};
    vecs[1] = '{"o4s3", 4'd4, 4'd3, 1'b0, 1'b0, BEAT0, BEAT1, 128'h07060504};
    vecs[2] = '{"o12s7", 4'd12, 4'd7, 1'b0, 1'b1, BEAT0, BEAT1, 128'h131211100F0E0D0C};
    vecs[3] = '{"o15s15", 4'd15, 4'd15, 1'b0, 1'b1, BEAT0, BEAT1,
                128'h1E1D1C1B1A191817161514131211100F};
    vecs[4] = '{"o15s1", 4'd15, 4'd1, 1'b0, 1'b1, BEAT0, BEAT1, 128'h100F};
    vecs[5] = '{"o9s0", 4'd9, 4'd0, 1'b0, 1'b0, BEAT0, BEAT1, 128'h09};
    vecs[6] = '{"o8s7", 4'd8, 4'd7, 1'b0, 1'b0, BEAT0, BEAT1, 128'h0F0E0D0C0B0A0908};
    vecs[7] = '{"o8s8", 4'd8, 4'd8, 1'b0, 1'b1, BEAT0, BEAT1, 128'h100F0E0D0C0B0A0908};
`ifdef LD_ALIGN_SEXT_EN
    vecs[8] = '{"sext_neg", 4'd2, 4'd1, 1'b1, 1'b0, SBEAT, BEAT1, {{112{1'b1}}, 16'h9234}};
`else
    vecs[8] = '{"sext_neg", 4'd2, 4'd1, 1'b1, 1'b0, SBEAT, BEAT1, 128'h9234};
`endif
    vecs[9] = '{"sext_pos", 4'd2, 4'd1, 1'b1, 1'b0, PBEAT, BEAT1, 128'h1234};

    rst_n = 1'b0; req_valid = 1'b0; req_offset = 4'd0; req_size = 4'd0; req_signed = 1'b0;
    beat_valid = 1'b0; beat_data = 128'd0; rsp_ready = 1'b0;
    step();
    step();
    chk("rst_req_ready", 128'(req_ready), 128'd1);
    chk("rst_beat_ready", 128'(beat_ready), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) run_load(vecs[i]);

    // Unsigned load of a negative byte stays zero-filled in either build.
    begin
      vec_t u;
      u = '{"unsigned_neg", 4'd2, 4'd1, 1'b0, 1'b0, SBEAT, BEAT1, 128'h9234};
      run_load(u);
    end

    // Back-pressure: stray beat during RESP, stall 5 cycles, queued request accepted after release.
    wait_req_ready("bp");
    req_valid = 1'b1; req_offset = 4'd4; req_size = 4'd3; req_signed = 1'b0;
    step();
    req_valid = 1'b0;
    beat_valid = 1'b1; beat_data = BEAT0;
    step();
    beat_data = BEAT1;
    req_valid = 1'b1; req_offset = 4'd0; req_size = 4'd15;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 128'(rsp_valid), 128'd1);
      chk("bp_rsp_data", rsp_data, 128'h07060504);
      chk("bp_req_ready", 128'(req_ready), 128'd0);
      chk("bp_beat_ready", 128'(beat_ready), 128'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_req_ready_back", 128'(req_ready), 128'd1);
    chk("bp_beat_held", 128'(beat_ready), 128'd0);
    step();
    req_valid = 1'b0;
    chk("bp_accepted", 128'(req_ready), 128'd0);
    chk("bp_b0_ready", 128'(beat_ready), 128'd1);
    step();
    beat_valid = 1'b0;
    chk("bp2_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("bp2_data", rsp_data, BEAT1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset while waiting for the second beat, then a fresh load.
    wait_req_ready("rst_mid");
    req_valid = 1'b1; req_offset = 4'd12; req_size = 4'd7;
    step();
    req_valid = 1'b0;
    beat_valid = 1'b1; beat_data = BEAT0;
    step();
    beat_valid = 1'b0;
    chk("mid_in_b1", 128'(beat_ready), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_req_ready", 128'(req_ready), 128'd1);
    chk("mid_beat_ready", 128'(beat_ready), 128'd0);
    chk("mid_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("mid_rsp_data", rsp_data, 128'd0);
    step();
    rst_n = 1'b1;
    step();
    run_load(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
